// File: rtl/control_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | control_pkg: shared encodings for the multicycle RV32I control unit      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package control_pkg;

    typedef logic [2:0] state_t;

    localparam state_t c_st_fetch     = 3'd0;
    localparam state_t c_st_decode    = 3'd1;
    localparam state_t c_st_execute   = 3'd2;
    localparam state_t c_st_memory    = 3'd3;
    localparam state_t c_st_writeback = 3'd4;
    localparam state_t c_st_halt      = 3'd5;

    localparam logic [6:0] c_op_r      = 7'b0110011;
    localparam logic [6:0] c_op_i_alu  = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;

    localparam logic [1:0] c_a_rs1   = 2'd0;
    localparam logic [1:0] c_a_pc    = 2'd1;
    localparam logic [1:0] c_a_zero  = 2'd2;

    localparam logic [1:0] c_b_rs2   = 2'd0;
    localparam logic [1:0] c_b_imm   = 2'd1;
    localparam logic [1:0] c_b_four  = 2'd2;

    localparam logic [1:0] c_alu_add   = 2'd0;
    localparam logic [1:0] c_alu_sub   = 2'd1;
    localparam logic [1:0] c_alu_funct = 2'd2;

    localparam logic [1:0] c_m2r_alu = 2'd0;
    localparam logic [1:0] c_m2r_mem = 2'd1;
    localparam logic [1:0] c_m2r_pc4 = 2'd2;

    typedef enum logic [3:0] {
        CLS_R,
        CLS_I_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_LUI,
        CLS_AUIPC,
        CLS_JAL,
        CLS_JALR,
        CLS_ILLEGAL
    } instr_class_t;

endpackage
`default_nettype wire

// File: rtl/control_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | control_decode: opcode -> instruction class, with illegal flag.          |
// | Macro CONTROL_JUMP_EN makes JAL/JALR legal. Revision: 1.0                |
// +--------------------------------------------------------------------------+
module control_decode
    import control_pkg::*;
(
    input  logic [6:0]   i_opcode,
    output instr_class_t o_instr_class,
    output logic         o_illegal
);

`ifdef CONTROL_JUMP_EN
    localparam logic c_jump_en = 1'b1;
`else
    localparam logic c_jump_en = 1'b0;
`endif

    always_comb begin
        o_instr_class = CLS_ILLEGAL;
        case (i_opcode)
            c_op_r:      o_instr_class = CLS_R;
            c_op_i_alu:  o_instr_class = CLS_I_ALU;
            c_op_load:   o_instr_class = CLS_LOAD;
            c_op_store:  o_instr_class = CLS_STORE;
            c_op_branch: o_instr_class = CLS_BRANCH;
            c_op_lui:    o_instr_class = CLS_LUI;
            c_op_auipc:  o_instr_class = CLS_AUIPC;
            c_op_jal:    o_instr_class = c_jump_en ? CLS_JAL  : CLS_ILLEGAL;
            c_op_jalr:   o_instr_class = c_jump_en ? CLS_JALR : CLS_ILLEGAL;
            default:     o_instr_class = CLS_ILLEGAL;
        endcase
    end

    assign o_illegal = (o_instr_class == CLS_ILLEGAL);

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_control: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer with |
// | memory timeout and retire counter. Macro CONTROL_JUMP_EN. Revision: 1.0  |
// +--------------------------------------------------------------------------+
module multicycle_control
    import control_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opcode,
    input  logic                 zero,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    output logic                 imem_req,
    output logic                 dmem_read,
    output logic                 dmem_write,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 branch,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic [1:0]           mem_to_reg,
    output logic                 reg_write,
    output logic                 illegal,
    output logic                 fault,
    output logic                 retire,
    output logic [CNT_WIDTH-1:0] retire_cnt
);

    localparam int c_wait_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(TIMEOUT_CYCLES - 1);

    state_t                r_state;
    state_t                w_next_state;
    logic [6:0]            r_opcode;
    logic [c_wait_w-1:0]   r_wait_cnt;
    logic                  r_fault;
    logic [CNT_WIDTH-1:0]  r_retire_cnt;

    instr_class_t          w_class;
    logic                  w_illegal;
    logic                  w_waiting;
    logic                  w_timeout;

    logic                  w_imem_req, w_dmem_read, w_dmem_write, w_ir_write;
    logic                  w_pc_write, w_branch, w_reg_write, w_illegal_pulse, w_retire;
    logic [1:0]            w_alu_src_a, w_alu_src_b, w_alu_op, w_mem_to_reg;

    // The branch condition is consumed by the datapath together with BRANCH.
    logic                  w_unused_zero;
    assign w_unused_zero = zero;

    control_decode u_decode (
        .i_opcode      (r_opcode),
        .o_instr_class (w_class),
        .o_illegal     (w_illegal)
    );

    assign w_waiting = ((r_state == c_st_fetch)  && !imem_ready) ||
                       ((r_state == c_st_memory) && !dmem_ready);
    assign w_timeout = w_waiting && (r_wait_cnt == c_wait_last);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_fetch: begin
                if (imem_ready)     w_next_state = c_st_decode;
                else if (w_timeout) w_next_state = c_st_halt;
            end
            c_st_decode:
                w_next_state = w_illegal ? c_st_fetch : c_st_execute;
            c_st_execute: begin
                case (w_class)
                    CLS_LOAD, CLS_STORE: w_next_state = c_st_memory;
                    CLS_BRANCH:          w_next_state = c_st_fetch;
                    CLS_ILLEGAL:         w_next_state = c_st_fetch;
                    default:             w_next_state = c_st_writeback;
                endcase
            end
            c_st_memory: begin
                if (dmem_ready)
                    w_next_state = (w_class == CLS_LOAD) ? c_st_writeback : c_st_fetch;
                else if (w_timeout)
                    w_next_state = c_st_halt;
            end
            c_st_writeback: w_next_state = c_st_fetch;
            c_st_halt:      w_next_state = c_st_halt;
            default:        w_next_state = c_st_fetch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_fetch;
            r_opcode     <= 7'd0;
            r_wait_cnt   <= '0;
            r_fault      <= 1'b0;
            r_retire_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == c_st_fetch) && imem_ready)
                r_opcode <= opcode;
            // A timeout leaves the waiting state, so the counter restarts from zero.
            if (w_waiting && !w_timeout)
                r_wait_cnt <= r_wait_cnt + c_wait_w'(1);
            else
                r_wait_cnt <= '0;
            if (w_timeout)
                r_fault <= 1'b1;
            if (w_retire)
                r_retire_cnt <= r_retire_cnt + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        w_imem_req      = 1'b0;
        w_dmem_read     = 1'b0;
        w_dmem_write    = 1'b0;
        w_ir_write      = 1'b0;
        w_pc_write      = 1'b0;
        w_branch        = 1'b0;
        w_reg_write     = 1'b0;
        w_illegal_pulse = 1'b0;
        w_retire        = 1'b0;
        w_alu_src_a     = c_a_rs1;
        w_alu_src_b     = c_b_rs2;
        w_alu_op        = c_alu_add;
        w_mem_to_reg    = c_m2r_alu;
        case (r_state)
            c_st_fetch: begin
                w_imem_req  = 1'b1;
                w_alu_src_a = c_a_pc;
                w_alu_src_b = c_b_four;
                w_ir_write  = imem_ready;
                w_pc_write  = imem_ready;
            end
            c_st_decode: w_illegal_pulse = w_illegal;
            c_st_execute: begin
                case (w_class)
                    CLS_R: w_alu_op = c_alu_funct;
                    CLS_I_ALU: begin
                        w_alu_src_b = c_b_imm;
                        w_alu_op    = c_alu_funct;
                    end
                    CLS_LOAD, CLS_STORE: w_alu_src_b = c_b_imm;
                    CLS_BRANCH: begin
                        w_alu_op = c_alu_sub;
                        w_branch = 1'b1;
                        w_retire = 1'b1;
                    end
                    CLS_LUI: begin
                        w_alu_src_a = c_a_zero;
                        w_alu_src_b = c_b_imm;
                    end
                    CLS_AUIPC, CLS_JAL: begin
                        w_alu_src_a = c_a_pc;
                        w_alu_src_b = c_b_imm;
                        w_pc_write  = (w_class == CLS_JAL);
                    end
                    CLS_JALR: begin
                        w_alu_src_b = c_b_imm;
                        w_pc_write  = 1'b1;
                    end
                    default: ;
                endcase
            end
            c_st_memory: begin
                w_dmem_read  = (w_class == CLS_LOAD);
                w_dmem_write = (w_class == CLS_STORE);
                w_retire     = (w_class == CLS_STORE) && dmem_ready;
            end
            c_st_writeback: begin
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
                if (w_class == CLS_LOAD)
                    w_mem_to_reg = c_m2r_mem;
                else if ((w_class == CLS_JAL) || (w_class == CLS_JALR))
                    w_mem_to_reg = c_m2r_pc4;
            end
            default: ;
        endcase
    end

    assign imem_req   = w_imem_req      & ~rst;
    assign dmem_read  = w_dmem_read     & ~rst;
    assign dmem_write = w_dmem_write    & ~rst;
    assign ir_write   = w_ir_write      & ~rst;
    assign pc_write   = w_pc_write      & ~rst;
    assign branch     = w_branch        & ~rst;
    assign reg_write  = w_reg_write     & ~rst;
    assign illegal    = w_illegal_pulse & ~rst;
    assign retire     = w_retire        & ~rst;
    assign fault      = r_fault         & ~rst;
    assign alu_src_a  = rst ? 2'd0 : w_alu_src_a;
    assign alu_src_b  = rst ? 2'd0 : w_alu_src_b;
    assign alu_op     = rst ? 2'd0 : w_alu_op;
    assign mem_to_reg = rst ? 2'd0 : w_mem_to_reg;
    assign retire_cnt = rst ? '0 : r_retire_cnt;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_multicycle_control: randomized bench with an instruction-level model. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_multicycle_control;

    localparam int TO = 4;
    localparam int CW = 4;
`ifdef CONTROL_JUMP_EN
    localparam bit JEN = 1'b1;
`else
    localparam bit JEN = 1'b0;
`endif

    localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_LUI = 5,
                   K_AUI = 6, K_JAL = 7, K_JALR = 8, K_ILL = 9;

    logic clk = 1'b1;
    logic rst, zero, imem_ready, dmem_ready;
    logic [6:0] opcode;
    logic imem_req, dmem_read, dmem_write, ir_write, pc_write, branch;
    logic [1:0] alu_src_a, alu_src_b, alu_op, mem_to_reg;
    logic reg_write, illegal, fault, retire;
    logic [CW-1:0] retire_cnt;

    multicycle_control #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .dmem_read(dmem_read), .dmem_write(dmem_write),
        .ir_write(ir_write), .pc_write(pc_write), .branch(branch),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .illegal(illegal),
        .fault(fault), .retire(retire), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic imem_req, dmem_read, dmem_write, ir_write, pc_write, branch;
        logic [1:0] a, b, op, m2r;
        logic reg_write, illegal, fault, retire;
        logic [CW-1:0] cnt;
    } out_t;

    out_t exp_q[$];
    int   checks = 0, errors = 0;
    int   m_cnt = 0;
    logic m_fault = 1'b0;
    bit   g_force = 1'b0;
    int   n_cyc, n_regw, n_pcw, n_rd, n_ill, n_br;
    int   regw_at[2];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic out_t actual();
        return {imem_req, dmem_read, dmem_write, ir_write, pc_write, branch,
                alu_src_a, alu_src_b, alu_op, mem_to_reg,
                reg_write, illegal, fault, retire, retire_cnt};
    endfunction

    always @(negedge clk) begin : compare
        out_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = actual();
            chk("outputs", {10'd0, a}, {10'd0, e});
            n_cyc++;
            if (a.reg_write) begin
                if (n_regw < 2) regw_at[n_regw] = n_cyc;
                n_regw++;
            end
            n_pcw += int'(a.pc_write);
            n_rd  += int'(a.dmem_read);
            n_ill += int'(a.illegal);
            n_br  += int'(a.branch);
        end
    end

    function automatic int cls(input logic [6:0] op);
        case (op)
            7'b0110011: return K_R;
            7'b0010011: return K_I;
            7'b0000011: return K_LD;
            7'b0100011: return K_ST;
            7'b1100011: return K_BR;
            7'b0110111: return K_LUI;
            7'b0010111: return K_AUI;
            7'b1101111: return JEN ? K_JAL : K_ILL;
            7'b1100111: return JEN ? K_JALR : K_ILL;
            default:    return K_ILL;
        endcase
    endfunction

    function automatic logic rb();
        return g_force ? 1'b1 : 1'($urandom);
    endfunction

    function automatic logic [6:0] rop();
        return 7'($urandom);
    endfunction

    function automatic out_t fe();
        out_t e = '0;
        e.imem_req = 1'b1;
        e.a = 2'd1;
        e.b = 2'd2;
        return e;
    endfunction

    // One clock cycle: drive inputs, record what the outputs must be during it.
    task automatic cycle(input logic ir, input logic dr, input logic [6:0] op, input out_t e_in);
        out_t e = e_in;
        if (!rst) begin
            e.fault = m_fault;
            e.cnt   = m_cnt[CW-1:0];
        end
        imem_ready = ir;
        dmem_ready = dr;
        opcode     = op;
        zero       = g_force ? 1'b1 : 1'($urandom);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (e.retire && !rst) m_cnt = (m_cnt + 1) % (1 << CW);
    endtask

    task automatic do_reset(input int n);
        rst     = 1'b1;
        m_cnt   = 0;
        m_fault = 1'b0;
        repeat (n) cycle(rb(), rb(), rop(), '0);
        rst = 1'b0;
    endtask

    task automatic halt_cycles(input int n);
        repeat (n) cycle(rb(), rb(), rop(), '0);
    endtask

    task automatic clr();
        n_cyc = 0; n_regw = 0; n_pcw = 0; n_rd = 0; n_ill = 0; n_br = 0;
        regw_at[0] = 0; regw_at[1] = 0;
    endtask

    // One instruction: iw fetch waits, dw memory waits (>= TO means never ready),
    // abort_at = memory wait index at which reset is applied (-1 for none).
    task automatic run_instr(input logic [6:0] op, input int iw, input int dw, input int abort_at);
        int   k = cls(op);
        out_t e;
        for (int i = 0; i < iw; i++) cycle(1'b0, rb(), rop(), fe());
        e = fe(); e.ir_write = 1'b1; e.pc_write = 1'b1;
        cycle(1'b1, rb(), op, e);
        e = '0;
        if (k == K_ILL) begin
            e.illegal = 1'b1;
            cycle(rb(), rb(), rop(), e);
            return;
        end
        cycle(rb(), rb(), rop(), e);
        e = '0;
        case (k)
            K_R:         e.op = 2'd2;
            K_I:         begin e.b = 2'd1; e.op = 2'd2; end
            K_LD, K_ST:  e.b = 2'd1;
            K_BR:        begin e.op = 2'd1; e.branch = 1'b1; e.retire = 1'b1; end
            K_LUI:       begin e.a = 2'd2; e.b = 2'd1; end
            K_AUI:       begin e.a = 2'd1; e.b = 2'd1; end
            K_JAL:       begin e.a = 2'd1; e.b = 2'd1; e.pc_write = 1'b1; end
            K_JALR:      begin e.b = 2'd1; e.pc_write = 1'b1; end
            default: ;
        endcase
        cycle(rb(), rb(), rop(), e);
        if (k == K_BR) return;
        if (k == K_LD || k == K_ST) begin
            e = '0;
            e.dmem_read  = (k == K_LD);
            e.dmem_write = (k == K_ST);
            for (int i = 0; i < dw && i < TO; i++) begin
                if (i == abort_at) begin
                    do_reset(1);
                    return;
                end
                cycle(rb(), 1'b0, rop(), e);
            end
            if (dw >= TO) begin
                m_fault = 1'b1;
                return;
            end
            e.retire = (k == K_ST);
            cycle(rb(), 1'b1, rop(), e);
            if (k == K_ST) return;
        end
        e = '0;
        e.reg_write = 1'b1;
        e.retire    = 1'b1;
        e.m2r       = (k == K_LD) ? 2'd1 : ((k == K_JAL || k == K_JALR) ? 2'd2 : 2'd0);
        cycle(rb(), rb(), rop(), e);
    endtask

    initial begin : main
        logic [6:0] ops[9];
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
        rst = 1'b1; zero = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; opcode = 7'd0;
        clr();
        do_reset(2);

        // R then I-ALU with instruction memory always ready
        clr(); g_force = 1'b1;
        run_instr(7'b0110011, 0, 0, -1);
        run_instr(7'b0010011, 0, 0, -1);
        chk("t1_retire_cnt", 32'(retire_cnt), 32'd2);
        chk("t1_regwrite_cycles", 32'(regw_at[0] * 256 + regw_at[1]), 32'h0408);
        chk("t1_pc_writes", 32'(n_pcw), 32'd2);
        chk("t1_cycles", 32'(n_cyc), 32'd8);

        // LOAD with data memory three cycles late
        clr(); g_force = 1'b0;
        run_instr(7'b0000011, 0, 3, -1);
        chk("t2_dmem_read_cycles", 32'(n_rd), 32'd4);
        chk("t2_cycles", 32'(n_cyc), 32'd8);
        chk("t2_reg_writes", 32'(n_regw), 32'd1);
        chk("t2_retire_cnt", 32'(retire_cnt), 32'd3);

        // BRANCH with ZERO=1
        clr(); g_force = 1'b1;
        run_instr(7'b1100011, 0, 0, -1);
        chk("t3_branch_cycles", 32'(n_br), 32'd1);
        chk("t3_reg_writes", 32'(n_regw), 32'd0);
        chk("t3_cycles", 32'(n_cyc), 32'd3);
        chk("t3_next_fetch", 32'(imem_req), 32'd1);
        chk("t3_retire_cnt", 32'(retire_cnt), 32'd4);

        // Illegal opcode, then JAL
        clr(); g_force = 1'b0;
        run_instr(7'b1111111, 0, 0, -1);
        chk("t4_illegal_pulses", 32'(n_ill), 32'd1);
        chk("t4_cycles", 32'(n_cyc), 32'd2);
        chk("t4_retire_cnt", 32'(retire_cnt), 32'd4);
        chk("t4_fetch_next", 32'(imem_req), 32'd1);
        clr();
        run_instr(7'b1101111, 0, 0, -1);
        chk("t4_jal_illegal", 32'(n_ill), JEN ? 32'd0 : 32'd1);
        chk("t4_jal_cycles", 32'(n_cyc), JEN ? 32'd4 : 32'd2);

        // STORE whose data memory never answers
        run_instr(7'b0100011, 0, 100, -1);
        halt_cycles(5);
        chk("t5_fault", 32'(fault), 32'd1);
        chk("t5_halt_quiet", 32'({imem_req, dmem_read, dmem_write, reg_write, retire}), 32'd0);
        do_reset(1);
        #1;
        chk("t5_after_reset", 32'({fault, imem_req}), 32'd1);

        // Counter wrap at CNT_WIDTH=4
        repeat (17) run_instr(7'b0110011, int'($urandom % TO), 0, -1);
        chk("t6_wrap", 32'(retire_cnt), 32'd1);

        // Reset in the middle of a LOAD's memory phase
        run_instr(7'b0000011, 0, 5, 2);
        #1;
        chk("t6_abort_fetch", 32'({imem_req, dmem_read}), 32'd2);
        chk("t6_abort_cnt", 32'(retire_cnt), 32'd0);

        // Ready arriving on the last permitted wait cycle
        run_instr(7'b0000011, TO - 1, TO - 1, -1);
        chk("ready_wins", 32'(fault), 32'd0);

        // Randomized instruction stream
        repeat (250) begin
            int sel = int'($urandom % 12);
            int iw  = int'($urandom % TO);
            int dw  = int'($urandom % TO);
            if (sel < 9) begin
                run_instr(ops[sel], iw, dw, -1);
            end else if (sel == 9) begin
                run_instr(rop(), iw, dw, -1);
            end else if (sel == 10) begin
                if (($urandom % 4) == 0) begin
                    run_instr(7'b0100011, iw, 100, -1);
                    halt_cycles(3);
                    do_reset(1 + int'($urandom % 2));
                end else begin
                    do_reset(1);
                end
            end else begin
                run_instr(7'b0000011, iw, TO - 1, int'($urandom % (TO - 1)));
            end
        end

        @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
